// File: rtl/ula_multiciclo.sv
// ula_multiciclo: multi-cycle ALU with start/done handshake, shift-add MUL and restoring DIV/REM
module ula_multiciclo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       ULAOp,
  input  logic [WIDTH-1:0] operand_A,
  input  logic [WIDTH-1:0] operand_B,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DIV = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4, OP_OR = 3'd5, OP_NOT = 3'd6, OP_REM = 3'd7;

  logic [0:0]         r_state;
  logic [2:0]         r_op;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_result;
  logic [3:0]         r_flags;
  logic               r_done;
  logic               r_div_zero;

  logic               w_calc, w_dz, w_iter, w_ge, w_c, w_v;
  logic [2:0]         w_op;
  logic [WIDTH:0]     w_sum, w_diff, w_msum, w_rsh;
  logic [2*WIDTH-1:0] w_acc_nx;
  logic [WIDTH-1:0]   w_rem_nx, w_quo_nx, w_res;
  logic [3:0]         w_flags;

  // In CALC the datapath evaluates one iteration of the latched op; in IDLE it evaluates the live request
  always_comb begin
    w_calc   = r_state == CALC;
    w_op     = w_calc ? r_op : ULAOp;
    w_dz     = !w_calc && (ULAOp == OP_DIV || ULAOp == OP_REM) && operand_B == '0;
    w_iter   = (ULAOp == OP_MUL || ULAOp == OP_DIV || ULAOp == OP_REM) && !w_dz;
    w_sum    = {1'b0, operand_A} + {1'b0, operand_B};
    w_diff   = {1'b0, operand_A} - {1'b0, operand_B};
    w_msum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
    w_acc_nx = r_acc[0] ? {w_msum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};
    w_rsh    = {r_rem, r_quo[WIDTH-1]};
    w_ge     = w_rsh >= {1'b0, r_opnd};
    w_rem_nx = w_ge ? WIDTH'(w_rsh - {1'b0, r_opnd}) : w_rsh[WIDTH-1:0];
    w_quo_nx = {r_quo[WIDTH-2:0], w_ge};
    w_res    = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (operand_A[WIDTH-1] == operand_B[WIDTH-1]) && (w_sum[WIDTH-1] != operand_A[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = ~w_diff[WIDTH];
        w_v   = (operand_A[WIDTH-1] != operand_B[WIDTH-1]) && (w_diff[WIDTH-1] != operand_A[WIDTH-1]);
      end
      OP_MUL: begin
        w_res = w_acc_nx[WIDTH-1:0];
        w_c   = |w_acc_nx[2*WIDTH-1:WIDTH];
      end
      OP_DIV:  w_res = w_dz ? '1 : w_quo_nx;
      OP_AND:  w_res = operand_A & operand_B;
      OP_OR:   w_res = operand_A | operand_B;
      OP_NOT:  w_res = ~operand_A;
      default: w_res = w_dz ? operand_A : w_rem_nx;
    endcase
    w_flags = {w_v, w_c, w_res[WIDTH-1], w_res == '0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_op       <= '0;
      r_cnt      <= '0;
      r_opnd     <= '0;
      r_acc      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_result   <= '0;
      r_flags    <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!w_calc && start && !w_iter) begin
        r_result   <= w_res;
        r_flags    <= w_flags;
        r_div_zero <= w_dz;
        r_done     <= 1'b1;
      end else if (!w_calc && start) begin
        r_state <= CALC;
        r_op    <= ULAOp;
        r_cnt   <= '0;
        r_opnd  <= ULAOp == OP_MUL ? operand_A : operand_B;
        r_acc   <= {{WIDTH{1'b0}}, operand_B};
        r_rem   <= '0;
        r_quo   <= operand_A;
      end else if (w_calc) begin
        r_acc <= w_acc_nx;
        r_rem <= w_rem_nx;
        r_quo <= w_quo_nx;
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) begin
          r_state    <= IDLE;
          r_result   <= w_res;
          r_flags    <= w_flags;
          r_div_zero <= 1'b0;
          r_done     <= 1'b1;
        end
      end
    end
  end

  assign result   = r_result;
  assign flags    = r_flags;
  assign busy     = r_state == CALC;
  assign done     = r_done;
  assign div_zero = r_div_zero;
endmodule
